// File: rtl/vga_pkg.sv
// Shared definitions for the VGA overlay path.
//   H_ACTIVE_DFLT / V_ACTIVE_DFLT : default active-area size
//   motion_state_t                : box motion sequencer states
//   expand_bit()                  : one colour switch bit -> full-scale 8-bit channel
package vga_pkg;

  localparam int H_ACTIVE_DFLT = 640;
  localparam int V_ACTIVE_DFLT = 480;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    UPDATE_X   = 2'd1,
    UPDATE_Y   = 2'd2
  } motion_state_t;

  function automatic logic [7:0] expand_bit(input logic b);
    return {8{b}};
  endfunction

endpackage

// File: rtl/box_overlay_if.sv
// Video bus between the timing controller / pattern generator and the overlay.
//   master : drives position, timing, background RGB and switches; receives overlaid pixel
//   slave  : the overlay stage
interface box_overlay_if;
  logic [9:0] hPixel;
  logic [8:0] vLine;
  logic       vActive;
  logic       hSync;
  logic       vSync;
  logic [7:0] inRED;
  logic [7:0] inGRN;
  logic [7:0] inBLU;
  logic [9:0] SW;
  logic [7:0] RED;
  logic [7:0] GRN;
  logic [7:0] BLU;
  logic       hSyncOut;
  logic       vSyncOut;
  logic       vActiveOut;

  modport master (
    output hPixel, vLine, vActive, hSync, vSync, inRED, inGRN, inBLU, SW,
    input  RED, GRN, BLU, hSyncOut, vSyncOut, vActiveOut
  );

  modport slave (
    input  hPixel, vLine, vActive, hSync, vSync, inRED, inGRN, inBLU, SW,
    output RED, GRN, BLU, hSyncOut, vSyncOut, vActiveOut
  );
endinterface

// File: rtl/box_axis.sv
// One axis of box motion: position + direction register with bounce rule.
//   clock, rst : pixel clock, async active-low reset
//   en         : perform one step this cycle
//   spd        : step size in pixels/lines (0 = hold)
//   pos, dir   : top-left coordinate on this axis, 1 = moving towards LIMIT
module box_axis #(
  parameter int W     = 10,
  parameter int SIZE  = 32,
  parameter int LIMIT = 640
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         en,
  input  logic [2:0]   spd,
  output logic [W-1:0] pos,
  output logic         dir
);

  localparam logic [10:0]  LIM11   = 11'(LIMIT);
  localparam logic [10:0]  SIZE11  = 11'(SIZE);
  localparam logic [W-1:0] MAX_POS = W'(LIMIT - SIZE);

  // 11-bit arithmetic so pos + spd + SIZE never wraps before the compare.
  logic [10:0] pos_w;
  logic [10:0] reach;
  logic        hit_hi;
  logic        hit_lo;

  assign pos_w  = 11'(pos);
  assign reach  = pos_w + 11'(spd) + SIZE11;
  assign hit_hi = (reach >= LIM11);
  assign hit_lo = (pos_w <= 11'(spd));

  // spd = 0 must leave direction alone even when parked on a limit.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      pos <= '0;
      dir <= 1'b1;
    end else if (en && (spd != 3'd0)) begin
      if (dir) begin
        if (hit_hi) begin
          pos <= MAX_POS;
          dir <= 1'b0;
        end else begin
          pos <= pos + W'(spd);
        end
      end else begin
        if (hit_lo) begin
          pos <= '0;
          dir <= 1'b1;
        end else begin
          pos <= pos - W'(spd);
        end
      end
    end
  end

endmodule

// File: rtl/box_overlay.sv
// Bouncing-box sprite overlay between the pattern generator and the VGA pins.
//   clock, rst : pixel clock, async active-low reset
//   vid        : slave side of the video bus (timing/background in, overlaid pixel out)
// Pixel data and syncs are registered together: one clock of latency on all of them.
//
// state      | meaning
// WAIT_FRAME | idle, waiting for the end-of-active-video tick
// UPDATE_X   | step the horizontal position with the latched speed
// UPDATE_Y   | step the vertical position with the latched speed
module box_overlay
  import vga_pkg::*;
#(
  parameter int BOX_W    = 32,
  parameter int BOX_H    = 24,
  parameter int H_ACTIVE = H_ACTIVE_DFLT,
  parameter int V_ACTIVE = V_ACTIVE_DFLT
) (
  input  logic         clock,
  input  logic         rst,
  box_overlay_if.slave vid
);

  motion_state_t state;
  logic [2:0]    spd;
  logic          vactive_d;
  logic          tick;

  logic [9:0]    box_x;
  logic [8:0]    box_y;
  logic          dir_x;
  logic          dir_y;

  logic [10:0]   x_end;
  logic [10:0]   y_end;
  logic          in_box;
  logic [23:0]   box_rgb;
  logic          sw_unused;

  assign sw_unused = ^vid.SW[6:4];

  // Falling edge of vActive marks the start of vertical blanking.
  assign tick = vactive_d & ~vid.vActive;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= WAIT_FRAME;
      spd       <= '0;
      vactive_d <= 1'b0;
    end else begin
      vactive_d <= vid.vActive;
      case (state)
        WAIT_FRAME: begin
          if (tick) begin
            spd   <= vid.SW[2:0];
            state <= UPDATE_X;
          end
        end
        UPDATE_X: state <= UPDATE_Y;
        UPDATE_Y: state <= WAIT_FRAME;
        default:  state <= WAIT_FRAME;
      endcase
    end
  end

  box_axis #(.W(10), .SIZE(BOX_W), .LIMIT(H_ACTIVE)) u_axis_x (
    .clock (clock),
    .rst   (rst),
    .en    (state == UPDATE_X),
    .spd   (spd),
    .pos   (box_x),
    .dir   (dir_x)
  );

  box_axis #(.W(9), .SIZE(BOX_H), .LIMIT(V_ACTIVE)) u_axis_y (
    .clock (clock),
    .rst   (rst),
    .en    (state == UPDATE_Y),
    .spd   (spd),
    .pos   (box_y),
    .dir   (dir_y)
  );

  assign x_end  = 11'(box_x) + 11'(BOX_W);
  assign y_end  = 11'(box_y) + 11'(BOX_H);
  assign in_box = vid.vActive & ~vid.SW[3]
                & (11'(vid.hPixel) >= 11'(box_x)) & (11'(vid.hPixel) < x_end)
                & (11'(vid.vLine)  >= 11'(box_y)) & (11'(vid.vLine)  < y_end);

  assign box_rgb = {expand_bit(vid.SW[9]), expand_bit(vid.SW[8]), expand_bit(vid.SW[7])};

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      vid.RED        <= '0;
      vid.GRN        <= '0;
      vid.BLU        <= '0;
      vid.hSyncOut   <= 1'b1;
      vid.vSyncOut   <= 1'b1;
      vid.vActiveOut <= 1'b0;
    end else begin
      vid.hSyncOut   <= vid.hSync;
      vid.vSyncOut   <= vid.vSync;
      vid.vActiveOut <= vid.vActive;
      if (!vid.vActive) begin
        {vid.RED, vid.GRN, vid.BLU} <= '0;
      end else if (in_box) begin
        {vid.RED, vid.GRN, vid.BLU} <= box_rgb;
      end else begin
        {vid.RED, vid.GRN, vid.BLU} <= {vid.inRED, vid.inGRN, vid.inBLU};
      end
    end
  end

endmodule

// File: tb/tb_box_overlay.sv
module tb_box_overlay;
  import vga_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  box_overlay_if vid ();

  box_overlay #(.BOX_W(32), .BOX_H(24), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clock (clk),
    .rst   (rst_n),
    .vid   (vid)
  );

  localparam logic [23:0] BG = 24'h0A141E;

  int n_checks = 0;
  int n_errors = 0;
  int ex = 0, ey = 0;
  bit edx = 1'b1, edy = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rgb_out();
    return {8'h00, vid.RED, vid.GRN, vid.BLU};
  endfunction

  task automatic drive_pix(input int h, input int v, input bit act, input bit hs, input bit vs);
    vid.hPixel  = 10'(h);
    vid.vLine   = 9'(v);
    vid.vActive = act;
    vid.hSync   = hs;
    vid.vSync   = vs;
  endtask

  task automatic pix_chk(input string tag, input int h, input int v, input bit act, input logic [23:0] exp_rgb);
    drive_pix(h, v, act, 1'b1, 1'b1);
    clk1();
    chk(tag, rgb_out(), 32'(exp_rgb));
  endtask

  task automatic mstep(input int p, input bit d, input int s, input int size, input int lim,
                       output int np, output bit nd);
    np = p;
    nd = d;
    if (s != 0) begin
      if (d) begin
        if (p + s + size >= lim) begin np = lim - size; nd = 1'b0; end
        else np = p + s;
      end else begin
        if (p <= s) begin np = 0; nd = 1'b1; end
        else np = p - s;
      end
    end
  endtask

  // One frame boundary: speed s is presented at the tick, live_sw replaces it right after.
  task automatic frame(input int s, input int live_sw);
    int nx, ny;
    bit ndx, ndy;
    vid.SW      = 10'(s);
    vid.vActive = 1'b1;
    clk1();
    vid.vActive = 1'b0;
    clk1();
    vid.SW = 10'(live_sw);
    mstep(ex, edx, s, 32, 640, nx, ndx);
    mstep(ey, edy, s, 24, 480, ny, ndy);
    chk("x_hold", 32'(dut.box_x), 32'(ex));
    clk1();
    chk("x_upd", 32'(dut.box_x), 32'(nx));
    chk("y_hold", 32'(dut.box_y), 32'(ey));
    clk1();
    chk("y_upd", 32'(dut.box_y), 32'(ny));
    chk("dir_x", 32'(dut.dir_x), 32'(ndx));
    chk("dir_y", 32'(dut.dir_y), 32'(ndy));
    ex = nx; ey = ny; edx = ndx; edy = ndy;
    clk1();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vid.hPixel = '0; vid.vLine = '0; vid.vActive = 1'b1;
    vid.hSync = 1'b0; vid.vSync = 1'b0;
    vid.inRED = 8'd10; vid.inGRN = 8'd20; vid.inBLU = 8'd30;
    vid.SW = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", rgb_out(), 32'h0);
    chk("rst_hso", 32'(vid.hSyncOut), 32'd1);
    chk("rst_vso", 32'(vid.vSyncOut), 32'd1);
    chk("rst_vao", 32'(vid.vActiveOut), 32'd0);
    chk("rst_x", 32'(dut.box_x), 32'd0);
    chk("rst_y", 32'(dut.box_y), 32'd0);
    chk("rst_dx", 32'(dut.dir_x), 32'd1);
    chk("rst_dy", 32'(dut.dir_y), 32'd1);
    rst_n = 1'b1;

    // latency and sync alignment
    drive_pix(100, 100, 1'b1, 1'b0, 1'b1);
    #1;
    chk("lat_pre", rgb_out(), 32'h0);
    clk1();
    chk("lat_bg", rgb_out(), 32'(BG));
    chk("lat_hso", 32'(vid.hSyncOut), 32'd0);
    chk("lat_vso", 32'(vid.vSyncOut), 32'd1);
    chk("lat_vao", 32'(vid.vActiveOut), 32'd1);
    drive_pix(0, 0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("lat_hold", rgb_out(), 32'(BG));
    clk1();
    chk("box_0_0", rgb_out(), 32'h0);
    chk("lat_hso2", 32'(vid.hSyncOut), 32'd1);
    chk("lat_vso2", 32'(vid.vSyncOut), 32'd0);

    pix_chk("box_31_23", 31, 23, 1'b1, 24'h0);
    pix_chk("edge_32_23", 32, 23, 1'b1, BG);
    pix_chk("edge_31_24", 31, 24, 1'b1, BG);
    pix_chk("box_0_23", 0, 23, 1'b1, 24'h0);
    pix_chk("far_639_479", 639, 479, 1'b1, BG);

    vid.SW = 10'h008;
    pix_chk("hide", 5, 5, 1'b1, BG);
    vid.SW = 10'h280;
    pix_chk("colour_101", 5, 5, 1'b1, 24'hFF00FF);
    pix_chk("colour_out", 40, 5, 1'b1, BG);
    pix_chk("blank_rgb", 5, 5, 1'b0, 24'h0);
    chk("blank_vao", 32'(vid.vActiveOut), 32'd0);
    repeat (3) clk1();
    chk("spd0_x", 32'(dut.box_x), 32'd0);
    chk("spd0_dx", 32'(dut.dir_x), 32'd1);
    vid.SW = '0;

    frame(4, 4);
    chk("f1_x", 32'(dut.box_x), 32'd4);
    chk("f1_y", 32'(dut.box_y), 32'd4);
    frame(4, 4);
    chk("f2_x", 32'(dut.box_x), 32'd8);
    frame(4, 4);
    chk("f3_x", 32'(dut.box_x), 32'd12);
    chk("f3_y", 32'(dut.box_y), 32'd12);

    vid.SW = '0;
    pix_chk("mv_in", 12, 12, 1'b1, 24'h0);
    pix_chk("mv_left", 11, 12, 1'b1, BG);
    pix_chk("mv_corner", 43, 35, 1'b1, 24'h0);
    pix_chk("mv_right", 44, 12, 1'b1, BG);
    pix_chk("mv_below", 12, 36, 1'b1, BG);

    for (int i = 0; i < 148; i++) frame(4, 4);
    chk("f151_x", 32'(dut.box_x), 32'd604);
    chk("f151_dx", 32'(dut.dir_x), 32'd1);
    chk("f151_y", 32'(dut.box_y), 32'd308);
    chk("f151_dy", 32'(dut.dir_y), 32'd0);

    frame(7, 7);
    chk("bounce_x", 32'(dut.box_x), 32'd608);
    chk("bounce_dx", 32'(dut.dir_x), 32'd0);
    frame(7, 7);
    chk("after_bx", 32'(dut.box_x), 32'd601);
    chk("after_by", 32'(dut.box_y), 32'd294);

    frame(7, 1);
    for (int i = 0; i < 40; i++) frame(7, 7);
    chk("desc_y", 32'(dut.box_y), 32'd7);
    frame(4, 4);
    chk("y3", 32'(dut.box_y), 32'd3);
    chk("y3_dy", 32'(dut.dir_y), 32'd0);
    frame(3, 3);
    chk("bounce_y", 32'(dut.box_y), 32'd0);
    chk("bounce_dy", 32'(dut.dir_y), 32'd1);
    chk("x307", 32'(dut.box_x), 32'd307);
    frame(3, 3);
    chk("after_y", 32'(dut.box_y), 32'd3);
    chk("x304", 32'(dut.box_x), 32'd304);
    frame(0, 0);
    chk("frozen_x", 32'(dut.box_x), 32'd304);
    chk("frozen_y", 32'(dut.box_y), 32'd3);

    // reset while the sequencer is in UPDATE_X
    vid.SW = 10'd5;
    drive_pix(50, 50, 1'b1, 1'b0, 1'b0);
    clk1();
    vid.vActive = 1'b0;
    clk1();
    chk("mid_state", 32'(dut.state), 32'(UPDATE_X));
    rst_n = 1'b0;
    #1;
    chk("mid_rgb", rgb_out(), 32'h0);
    chk("mid_hso", 32'(vid.hSyncOut), 32'd1);
    chk("mid_vso", 32'(vid.vSyncOut), 32'd1);
    chk("mid_x", 32'(dut.box_x), 32'd0);
    chk("mid_y", 32'(dut.box_y), 32'd0);
    chk("mid_st", 32'(dut.state), 32'(WAIT_FRAME));
    clk1();
    clk1();
    rst_n = 1'b1;
    ex = 0; ey = 0; edx = 1'b1; edy = 1'b1;
    frame(4, 4);
    chk("post_x", 32'(dut.box_x), 32'd4);
    chk("post_y", 32'(dut.box_y), 32'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
